// File: rtl/sym_eval_seq.sv
// sym_eval_seq: sequential symmetric-function evaluator, z = mask[popcount(in_data)], CHUNK bits per cycle.
// Optional: define SYM_EVAL_WEIGHT_OUT_EN to expose the final popcount on out_weight.
module sym_eval_seq #(
    parameter int N = 10,
    parameter int CHUNK = 4,
    parameter logic [N:0] DEFAULT_MASK = 11'h0F8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [N:0]    cfg_mask,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_z,
    output logic          busy
`ifdef SYM_EVAL_WEIGHT_OUT_EN
    ,
    output logic [CW-1:0] out_weight
`endif
);
    localparam int NCH = (N + CHUNK - 1) / CHUNK;
    localparam int SW = NCH * CHUNK;
    localparam int KW = $clog2(NCH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nx;
    logic [SW-1:0] sh;
    logic [CW-1:0] acc, pc;
    logic [KW-1:0] chunk_cnt;
    logic [N:0] mask_reg, snap;
    logic accept, last;

    assign accept = in_valid && state == IDLE;
    assign last = chunk_cnt == KW'(NCH - 1);
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign out_z = (state == DONE) && snap[acc];
`ifdef SYM_EVAL_WEIGHT_OUT_EN
    assign out_weight = state == DONE ? acc : '0;
`endif

    always_comb begin
        pc = '0;
        for (int i = 0; i < CHUNK; i++) pc = pc + CW'(sh[i]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ACCUM : IDLE;
            ACCUM:   state_nx = last ? DONE : ACCUM;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // A same-cycle config write is folded into the snapshot so it governs this vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg  <= DEFAULT_MASK;
            snap      <= DEFAULT_MASK;
            sh        <= '0;
            acc       <= '0;
            chunk_cnt <= '0;
        end else begin
            if (cfg_we) mask_reg <= cfg_mask;
            if (accept) begin
                sh        <= SW'(in_data);
                acc       <= '0;
                chunk_cnt <= '0;
                snap      <= cfg_we ? cfg_mask : mask_reg;
            end else if (state == ACCUM) begin
                acc       <= acc + pc;
                sh        <= sh >> CHUNK;
                chunk_cnt <= chunk_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sym_eval_seq.sv
// tb_sym_eval_seq: table-driven scoreboard bench for sym_eval_seq plus NCH=1 and padded NCH=4 variants.
module tb_sym_eval_seq;
    logic clk = 0;
    logic rst_n = 0;
    logic cfg_we = 0;
    logic [10:0] cfg_mask = '0;
    logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_z, busy;
    logic [9:0] in_data = '0;
    logic [3:0] out_weight;
    logic b_valid = 0, b_ready, b_ovalid, b_z, b_busy;
    logic [6:0] b_data = '0;
    logic [2:0] b_w;
    logic c_valid = 0, c_ready, c_ovalid, c_z, c_busy;
    logic [9:0] c_data = '0;
    logic [3:0] c_w;
    int tests = 0, fails = 0;
    logic [4:0] q[$];

    typedef struct {
        logic [9:0]  d;
        logic        we;
        logic        mid;
        logic [10:0] m;
        logic        z;
        logic [3:0]  w;
    } vec_t;

    always #5 clk = ~clk;

    sym_eval_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
`ifdef SYM_EVAL_WEIGHT_OUT_EN
        , .out_weight(out_weight)
`endif
    );

    sym_eval_seq #(.N(7), .CHUNK(7), .DEFAULT_MASK(8'hF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_mask(8'h00),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .out_valid(b_ovalid), .out_ready(1'b1), .out_z(b_z), .busy(b_busy)
`ifdef SYM_EVAL_WEIGHT_OUT_EN
        , .out_weight(b_w)
`endif
    );

    sym_eval_seq #(.N(10), .CHUNK(3), .DEFAULT_MASK(11'h0F8)) dut_c (
        .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_mask(11'h000),
        .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .out_valid(c_ovalid), .out_ready(1'b1), .out_z(c_z), .busy(c_busy)
`ifdef SYM_EVAL_WEIGHT_OUT_EN
        , .out_weight(c_w)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic xact(input vec_t v);
        int n;
        int lat;
        logic [4:0] e;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1;
        in_data = v.d;
        cfg_we = v.we;
        cfg_mask = v.m;
        @(posedge clk);
        q.push_back({v.z, v.w});
        #1;
        in_valid = 0;
        cfg_we = v.mid;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            cfg_we = 0;
            lat++;
        end
        chk("latency", lat, 3);
        if (out_valid) begin
            e = q.pop_front();
            chk("out_z", out_z, e[4]);
`ifdef SYM_EVAL_WEIGHT_OUT_EN
            chk("out_weight", out_weight, e[3:0]);
`endif
        end else chk("out_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        int n;
        int cnt;
        tbl = '{
            '{10'h01F, 1'b0, 1'b0, 11'h000, 1'b1, 4'd5},
            '{10'h3FF, 1'b0, 1'b0, 11'h000, 1'b0, 4'd10},
            '{10'h000, 1'b0, 1'b0, 11'h000, 1'b0, 4'd0},
            '{10'h007, 1'b0, 1'b0, 11'h000, 1'b1, 4'd3},
            '{10'h0FF, 1'b0, 1'b0, 11'h000, 1'b0, 4'd8},
            '{10'h07F, 1'b0, 1'b0, 11'h000, 1'b1, 4'd7},
            '{10'h3FF, 1'b1, 1'b0, 11'h401, 1'b1, 4'd10},
            '{10'h001, 1'b0, 1'b0, 11'h000, 1'b0, 4'd1},
            '{10'h000, 1'b0, 1'b0, 11'h000, 1'b1, 4'd0},
            '{10'h003, 1'b1, 1'b0, 11'h0F8, 1'b0, 4'd2},
            '{10'h01F, 1'b0, 1'b1, 11'h000, 1'b1, 4'd5},
            '{10'h01F, 1'b0, 1'b0, 11'h000, 1'b0, 4'd5},
            '{10'h007, 1'b1, 1'b0, 11'h0F8, 1'b1, 4'd3}
        };
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef SYM_EVAL_WEIGHT_OUT_EN
        chk("rst_out_weight", out_weight, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) xact(tbl[i]);

        // backpressure: result must hold and new vectors must be refused
        @(negedge clk);
        out_ready = 0;
        in_valid = 1;
        in_data = 10'h007;
        @(posedge clk);
        #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data = 10'h3FF;
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_z", out_z, 1);
            chk("bp_in_ready", in_ready, 0);
`ifdef SYM_EVAL_WEIGHT_OUT_EN
            chk("bp_hold_weight", out_weight, 3);
`endif
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);

        // async reset in the second accumulate cycle, after zeroing the mask
        @(negedge clk);
        in_valid = 1;
        in_data = 10'h01F;
        cfg_we = 1;
        cfg_mask = 11'h000;
        @(posedge clk);
        #1;
        in_valid = 0;
        cfg_we = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_z", out_z, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abandoned_no_out", cnt, 0);
        xact('{10'h01F, 1'b0, 1'b0, 11'h000, 1'b1, 4'd5});

        // NCH=1 variant: single-cycle accumulate
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b_valid = 1;
            b_data = i == 0 ? 7'h1F : 7'h03;
            @(posedge clk);
            #1;
            b_valid = 0;
            n = 0;
            while (!b_ovalid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("b_latency", n, 1);
            chk("b_z", b_z, i == 0 ? 1 : 0);
`ifdef SYM_EVAL_WEIGHT_OUT_EN
            chk("b_weight", b_w, i == 0 ? 5 : 2);
`endif
            @(negedge clk);
        end

        // NCH=4 variant with a zero-padded last chunk
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            c_valid = 1;
            c_data = i == 0 ? 10'h3FF : 10'h207;
            @(posedge clk);
            #1;
            c_valid = 0;
            n = 0;
            while (!c_ovalid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("c_latency", n, 4);
            chk("c_z", c_z, i == 0 ? 0 : 1);
`ifdef SYM_EVAL_WEIGHT_OUT_EN
            chk("c_weight", c_w, i == 0 ? 10 : 4);
`endif
            @(negedge clk);
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
